// File: rtl/vga_text_pkg.sv
// Shared constants and types for the 80x60 text-mode pixel back-end.
//  - Text grid geometry and fixed render latency.
//  - Bit positions of the fields inside a VRAM word.
//  - The per-pixel pipeline record carried from the sync inputs to the RGB register.
//  - The 16-entry 12-bit colour palette.
package vga_text_pkg;

  localparam int unsigned TEXT_COLS  = 80;
  localparam int unsigned TEXT_ROWS  = 60;
  localparam int unsigned RENDER_LAT = 4;

  // VRAM word layout: [7:0] char, [11:8] fg, [14:12] bg, [15] blink
  localparam int unsigned VRAM_CHAR_LSB  = 0;
  localparam int unsigned VRAM_FG_LSB    = 8;
  localparam int unsigned VRAM_BG_LSB    = 12;
  localparam int unsigned VRAM_BLINK_BIT = 15;

  // Everything the output stage needs about one pixel, apart from the glyph row itself.
  typedef struct packed {
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       we;
    logic       cur_hit;
    logic [2:0] x_lo;
    logic [2:0] y_lo;
    logic [3:0] fg;
    logic [2:0] bg;
    logic       blink;
  } pix_pipe_t;

  function automatic logic [11:0] palette(input logic [3:0] idx);
    logic [11:0] rgb;
    case (idx)
      4'h0:    rgb = 12'h000;
      4'h1:    rgb = 12'h00A;
      4'h2:    rgb = 12'h0A0;
      4'h3:    rgb = 12'h0AA;
      4'h4:    rgb = 12'hA00;
      4'h5:    rgb = 12'hA0A;
      4'h6:    rgb = 12'hA50;
      4'h7:    rgb = 12'hAAA;
      4'h8:    rgb = 12'h555;
      4'h9:    rgb = 12'h55F;
      4'hA:    rgb = 12'h5F5;
      4'hB:    rgb = 12'h5FF;
      4'hC:    rgb = 12'hF55;
      4'hD:    rgb = 12'hF5F;
      4'hE:    rgb = 12'hFF5;
      default: rgb = 12'hFFF;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/text_render_blink_timer.sv
// Blink timer for the text renderer.
//  Counts frame starts (vsync transitions into the active level) and toggles the blink
//  phase every BLINK_FRAMES frames.
// Ports:
//  i_clk          system clock
//  i_rst_n        synchronous reset, active-low
//  i_vsync        raw vsync from the sync generator
//  o_blink_phase  0 = visible half-period, 1 = blanked half-period
module text_render_blink_timer #(
  parameter int unsigned BLINK_FRAMES = 30,
  parameter logic        SYNC_IDLE    = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_vsync,
  output logic o_blink_phase
);

  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic             r_vs_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_phase;
  logic             w_phase_next;
  logic             w_frame_start;

  always_comb begin
    w_frame_start = (i_vsync != SYNC_IDLE) && (r_vs_prev == SYNC_IDLE);
    w_cnt_next    = r_cnt;
    w_phase_next  = r_phase;
    if (w_frame_start) begin
      if (r_cnt == CNT_LAST) begin
        w_cnt_next   = '0;
        w_phase_next = ~r_phase;
      end else begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vs_prev <= SYNC_IDLE;
      r_cnt     <= '0;
      r_phase   <= 1'b0;
    end else begin
      r_vs_prev <= i_vsync;
      r_cnt     <= w_cnt_next;
      r_phase   <= w_phase_next;
    end
  end

  assign o_blink_phase = r_phase;

endmodule

// File: rtl/text_render.sv
// Pixel back-end of the 80x60 text mode.
//  Takes the VRAM word for the current character cell, looks up the glyph row in the
//  synchronous font ROM and produces 12-bit RGB with syncs delayed to match. Adds the
//  per-character blink attribute and a two-line underline hardware cursor.
//  Fixed latency: inputs of cycle n appear on o_rgb/o_hsync_out/o_vsync_out after posedge n+4.
// Ports:
//  i_clk, i_rst_n        clock, synchronous active-low reset
//  i_x, i_y              current pixel column/row (same cycle as the VRAM address stage input)
//  i_video_on            visible-area flag
//  i_hsync_in/i_vsync_in raw syncs aligned with i_x/i_y
//  i_gpiovga_we          CPU VRAM write this cycle; the fetched word is not display data
//  i_vram_data           VRAM word, valid one cycle after i_x/i_y
//  o_font_addr           {char code, glyph row} to the font ROM
//  i_font_data           glyph row, bit 7 leftmost, valid one cycle after o_font_addr
//  i_cursor_en/col/row   hardware cursor control, sampled live
//  o_rgb                 {r,g,b} 4 bits each
//  o_hsync_out/o_vsync_out syncs aligned with o_rgb
module text_render
  import vga_text_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = 30,
  parameter logic        SYNC_IDLE    = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [10:0] i_x,
  input  logic [10:0] i_y,
  input  logic        i_video_on,
  input  logic        i_hsync_in,
  input  logic        i_vsync_in,
  input  logic        i_gpiovga_we,
  input  logic [15:0] i_vram_data,
  output logic [10:0] o_font_addr,
  input  logic [7:0]  i_font_data,
  input  logic        i_cursor_en,
  input  logic [6:0]  i_cursor_col,
  input  logic [5:0]  i_cursor_row,
  output logic [11:0] o_rgb,
  output logic        o_hsync_out,
  output logic        o_vsync_out
);

  // Pipe contents after reset: blanked pixel, syncs at their inactive level.
  function automatic pix_pipe_t pipe_idle();
    pix_pipe_t p;
    p       = '0;
    p.hsync = SYNC_IDLE;
    p.vsync = SYNC_IDLE;
    return p;
  endfunction

  pix_pipe_t   w_s1_next;
  pix_pipe_t   w_s2_next;
  pix_pipe_t   r_s1;
  pix_pipe_t   r_s2;
  pix_pipe_t   r_s3;
  logic [10:0] w_font_addr_next;
  logic [10:0] r_font_addr;
  logic        w_cur_hit;
  logic        w_blink_phase;
  logic        w_pix;
  logic [11:0] w_rgb_next;
  logic [11:0] r_rgb;
  logic        r_hsync;
  logic        r_vsync;

  text_render_blink_timer #(
    .BLINK_FRAMES (BLINK_FRAMES),
    .SYNC_IDLE    (SYNC_IDLE)
  ) u_blink_timer (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_vsync       (i_vsync_in),
    .o_blink_phase (w_blink_phase)
  );

  // S1: cell-level cursor compare. An off-grid cursor can still equal x[10:3]/y[10:3]
  // in the blanking area, so it is range-checked explicitly.
  always_comb begin
    w_cur_hit = i_cursor_en
              && (i_cursor_col < 7'(TEXT_COLS))
              && (i_cursor_row < 6'(TEXT_ROWS))
              && (i_x[10:3] == {1'b0, i_cursor_col})
              && (i_y[10:3] == {2'b00, i_cursor_row});

    w_s1_next          = '0;
    w_s1_next.video_on = i_video_on;
    w_s1_next.hsync    = i_hsync_in;
    w_s1_next.vsync    = i_vsync_in;
    w_s1_next.we       = i_gpiovga_we;
    w_s1_next.cur_hit  = w_cur_hit;
    w_s1_next.x_lo     = i_x[2:0];
    w_s1_next.y_lo     = i_y[2:0];
  end

  // S2: VRAM word arrives; split it into the font address and the colour attributes.
  always_comb begin
    w_s2_next        = r_s1;
    w_s2_next.fg     = i_vram_data[VRAM_FG_LSB +: 4];
    w_s2_next.bg     = i_vram_data[VRAM_BG_LSB +: 3];
    w_s2_next.blink  = i_vram_data[VRAM_BLINK_BIT];
    w_font_addr_next = {i_vram_data[VRAM_CHAR_LSB +: 8], r_s1.y_lo};
  end

  // S4: glyph bit selection, blink and cursor overrides, colour lookup.
  always_comb begin
    w_pix = i_font_data[3'd7 - r_s3.x_lo];
    if (r_s3.blink && w_blink_phase) begin
      w_pix = 1'b0;
    end
    // Underline cursor on the bottom two glyph rows, blinking in step with the attribute.
    if (r_s3.cur_hit && (r_s3.y_lo >= 3'd6) && !w_blink_phase) begin
      w_pix = 1'b1;
    end

    if (!r_s3.video_on) begin
      w_rgb_next = '0;
    end else if (r_s3.we) begin
      // The VRAM port was busy with the CPU write, so the fetched word is meaningless.
      w_rgb_next = palette(4'h0);
    end else if (w_pix) begin
      w_rgb_next = palette(r_s3.fg);
    end else begin
      w_rgb_next = palette({1'b0, r_s3.bg});
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1        <= pipe_idle();
      r_s2        <= pipe_idle();
      r_s3        <= pipe_idle();
      r_font_addr <= '0;
      r_rgb       <= '0;
      r_hsync     <= SYNC_IDLE;
      r_vsync     <= SYNC_IDLE;
    end else begin
      r_s1        <= w_s1_next;
      r_s2        <= w_s2_next;
      r_s3        <= r_s2;  // pure delay to line up with i_font_data
      r_font_addr <= w_font_addr_next;
      r_rgb       <= w_rgb_next;
      r_hsync     <= r_s3.hsync;
      r_vsync     <= r_s3.vsync;
    end
  end

  assign o_font_addr = r_font_addr;
  assign o_rgb       = r_rgb;
  assign o_hsync_out = r_hsync;
  assign o_vsync_out = r_vsync;

endmodule

// File: tb/tb_text_render.sv
// Self-checking bench for text_render. Emulates the VRAM address stage and the font ROM,
// predicts every output cycle from a pixel-level model, and adds directed vectors with
// hand-computed colours for the glyph, write-collision, cursor, sync and blink cases.
module tb_text_render;

  localparam int unsigned BF   = 2;
  localparam logic        IDLE = 1'b1;
  localparam int          MAXT = 8000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [10:0] x = '0;
  logic [10:0] y = '0;
  logic        video_on = 1'b0;
  logic        hsync_in = IDLE;
  logic        vsync_in = IDLE;
  logic        gpio_we = 1'b0;
  logic [15:0] vram_data = '0;
  logic [10:0] font_addr;
  logic [7:0]  font_data = '0;
  logic        cursor_en = 1'b0;
  logic [6:0]  cursor_col = '0;
  logic [5:0]  cursor_row = '0;
  logic [11:0] rgb;
  logic        hsync_out;
  logic        vsync_out;

  text_render #(
    .BLINK_FRAMES (BF),
    .SYNC_IDLE    (IDLE)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_x          (x),
    .i_y          (y),
    .i_video_on   (video_on),
    .i_hsync_in   (hsync_in),
    .i_vsync_in   (vsync_in),
    .i_gpiovga_we (gpio_we),
    .i_vram_data  (vram_data),
    .o_font_addr  (font_addr),
    .i_font_data  (font_data),
    .i_cursor_en  (cursor_en),
    .i_cursor_col (cursor_col),
    .i_cursor_row (cursor_row),
    .o_rgb        (rgb),
    .o_hsync_out  (hsync_out),
    .o_vsync_out  (vsync_out)
  );

  logic [15:0] vram_mem [4800];
  logic [7:0]  font_mem [2048];

  function automatic int cell_of(input logic [10:0] xx, input logic [10:0] yy);
    if (xx >= 11'd640 || yy >= 11'd480) return 0;
    return (int'(yy) / 8) * 80 + int'(xx) / 8;
  endfunction

  // Address stage + VRAM, and the synchronous font ROM.
  always @(posedge clk) begin
    vram_data <= vram_mem[cell_of(x, y)];
    font_data <= font_mem[font_addr];
  end

  function automatic logic [11:0] pal(input logic [3:0] i);
    logic [11:0] c;
    case (i)
      4'h0: c = 12'h000;  4'h1: c = 12'h00A;  4'h2: c = 12'h0A0;  4'h3: c = 12'h0AA;
      4'h4: c = 12'hA00;  4'h5: c = 12'hA0A;  4'h6: c = 12'hA50;  4'h7: c = 12'hAAA;
      4'h8: c = 12'h555;  4'h9: c = 12'h55F;  4'hA: c = 12'h5F5;  4'hB: c = 12'h5FF;
      4'hC: c = 12'hF55;  4'hD: c = 12'hF5F;  4'hE: c = 12'hFF5;  default: c = 12'hFFF;
    endcase
    return c;
  endfunction

  typedef struct packed {
    logic        rst_n;
    logic [10:0] x;
    logic [10:0] y;
    logic        von;
    logic        hs;
    logic        vs;
    logic        we;
    logic        cen;
    logic [6:0]  ccol;
    logic [5:0]  crow;
  } vec_t;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        von;
    logic        we;
    logic        cen;
    logic [11:0] exp_rgb;
  } tv_t;

  vec_t        hist    [MAXT];
  int unsigned pulses  [MAXT];
  bit          dir_vld [MAXT];
  logic [11:0] dir_rgb [MAXT];
  logic        obs_hs  [MAXT];
  int          t = 0;
  int          checks = 0;
  int          failures = 0;

  // Colour of one pixel from the text-mode rules.
  function automatic logic [11:0] model_rgb(input vec_t v, input bit phase);
    logic [15:0] w;
    logic [7:0]  row;
    bit          pix;
    bit          hit;
    w   = vram_mem[cell_of(v.x, v.y)];
    row = font_mem[{w[7:0], v.y[2:0]}];
    pix = row[7 - (int'(v.x) % 8)];
    hit = v.cen && (int'(v.ccol) < 80) && (int'(v.crow) < 60)
       && (int'(v.x) / 8 == int'(v.ccol)) && (int'(v.y) / 8 == int'(v.crow));
    if (w[15] && phase) pix = 1'b0;
    if (hit && (int'(v.y) % 8 >= 6) && !phase) pix = 1'b1;
    if (!v.von) return 12'h000;
    if (v.we) return 12'h000;
    return pix ? pal(w[11:8]) : pal({1'b0, w[14:12]});
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", name, t, act, exp);
    end
  endtask

  // Outputs seen now belong to the inputs applied four steps ago.
  task automatic check_outputs();
    int          s;
    bit          idle;
    bit          phase;
    vec_t        h;
    logic [15:0] w;
    if (t < 4) return;
    s    = t - 4;
    idle = 1'b0;
    for (int k = s; k < t; k++) if (!hist[k].rst_n) idle = 1'b1;
    if (idle) begin
      cmp("rgb_idle", 32'(rgb), 32'h0);
      cmp("hsync_idle", 32'(hsync_out), 32'(IDLE));
      cmp("vsync_idle", 32'(vsync_out), 32'(IDLE));
    end else begin
      h     = hist[s];
      phase = ((pulses[t-2] / BF) % 2) == 1;
      cmp("rgb", 32'(rgb), 32'(model_rgb(h, phase)));
      cmp("hsync", 32'(hsync_out), 32'(h.hs));
      cmp("vsync", 32'(vsync_out), 32'(h.vs));
    end
    if (dir_vld[s]) cmp("directed_rgb", 32'(rgb), 32'(dir_rgb[s]));
    if (!hist[t-1].rst_n) begin
      cmp("font_addr_rst", 32'(font_addr), 32'h0);
    end else if (hist[t-2].rst_n) begin
      h = hist[t-2];
      w = vram_mem[cell_of(h.x, h.y)];
      cmp("font_addr", 32'(font_addr), 32'({w[7:0], h.y[2:0]}));
    end
  endtask

  task automatic step(input vec_t v, input bit dv, input logic [11:0] de);
    logic prev_vs;
    if (t >= MAXT) begin
      failures++;
      $display("FAIL step_budget step=%0d actual=%0d required=<%0d", t, t, MAXT);
      $fatal(1, "step budget exhausted");
    end
    check_outputs();
    obs_hs[t]  = hsync_out;
    hist[t]    = v;
    dir_vld[t] = dv;
    dir_rgb[t] = de;
    prev_vs    = (t == 0) ? IDLE : (hist[t-1].rst_n ? hist[t-1].vs : IDLE);
    if (!v.rst_n) pulses[t] = 0;
    else begin
      pulses[t] = (t == 0) ? 0 : pulses[t-1];
      if (v.vs != IDLE && prev_vs == IDLE) pulses[t] = pulses[t] + 1;
    end
    rst_n      = v.rst_n;
    x          = v.x;
    y          = v.y;
    video_on   = v.von;
    hsync_in   = v.hs;
    vsync_in   = v.vs;
    gpio_we    = v.we;
    cursor_en  = v.cen;
    cursor_col = v.ccol;
    cursor_row = v.crow;
    @(negedge clk);
    t++;
  endtask

  function automatic vec_t vdef();
    vec_t v;
    v       = '0;
    v.rst_n = 1'b1;
    v.von   = 1'b1;
    v.hs    = IDLE;
    v.vs    = IDLE;
    return v;
  endfunction

  task automatic add_tv(inout tv_t q[$], input int xx, input int yy, input bit von,
                        input bit we, input bit cen, input logic [11:0] e);
    tv_t r;
    r.x = 11'(xx); r.y = 11'(yy); r.von = von; r.we = we; r.cen = cen; r.exp_rgb = e;
    q.push_back(r);
  endtask

  initial begin
    tv_t         tbl[$];
    vec_t        v;
    int          t0;
    int          lows;
    int          first;
    logic [11:0] blink_exp [4];

    for (int i = 0; i < 4800; i++) vram_mem[i] = 16'($urandom);
    for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);
    vram_mem[0]          = 16'h0F41;   // fg 15, bg 0, 'A'
    vram_mem[1]          = 16'h0F43;   // fg 15, bg 0, solid row 0
    vram_mem[2]          = 16'h9F41;   // blinking, fg 15, bg 1
    vram_mem[2 * 80 + 5] = 16'h2C42;   // cursor cell: fg 12, bg 2
    font_mem[{8'h41, 3'd0}] = 8'h81;
    font_mem[{8'h43, 3'd0}] = 8'hFF;
    font_mem[{8'h42, 3'd5}] = 8'h00;
    font_mem[{8'h42, 3'd6}] = 8'h00;
    font_mem[{8'h42, 3'd7}] = 8'h00;

    for (int i = 0; i < 8; i++)
      add_tv(tbl, i, 0, 1'b1, 1'b0, 1'b0, (i == 0 || i == 7) ? 12'hFFF : 12'h000);
    for (int i = 8; i < 16; i++)
      add_tv(tbl, i, 0, 1'b1, i == 11, 1'b0, (i == 11) ? 12'h000 : 12'hFFF);
    for (int yy = 21; yy < 24; yy++)
      for (int i = 40; i < 48; i++)
        add_tv(tbl, i, yy, 1'b1, 1'b0, 1'b1, (yy == 21) ? 12'h0A0 : 12'hF55);
    add_tv(tbl, 0, 0, 1'b0, 1'b0, 1'b0, 12'h000);
    add_tv(tbl, 8, 0, 1'b0, 1'b0, 1'b0, 12'h000);

    @(negedge clk);

    // Reset held three cycles with live inputs, then release.
    v = vdef();
    v.rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step(v, 1'b0, 12'h000);
    step(vdef(), 1'b1, 12'hFFF);

    foreach (tbl[i]) begin
      v      = vdef();
      v.x    = tbl[i].x;
      v.y    = tbl[i].y;
      v.von  = tbl[i].von;
      v.we   = tbl[i].we;
      v.cen  = tbl[i].cen;
      v.ccol = 7'd5;
      v.crow = 6'd2;
      step(v, 1'b1, tbl[i].exp_rgb);
    end
    v = vdef();
    v.von = 1'b0;
    for (int i = 0; i < 4; i++) step(v, 1'b0, 12'h000);

    // 96-cycle hsync pulse during blanking.
    t0 = t;
    v  = vdef();
    v.von = 1'b0;
    v.hs  = ~IDLE;
    for (int i = 0; i < 96; i++) begin
      v.x = 11'(i);
      step(v, 1'b0, 12'h000);
    end
    v.hs = IDLE;
    for (int i = 0; i < 10; i++) step(v, 1'b0, 12'h000);
    lows  = 0;
    first = -1;
    for (int k = t0; k < t; k++) begin
      if (obs_hs[k] === 1'b0) begin
        lows++;
        if (first < 0) first = k;
      end
    end
    cmp("hsync_pulse_len", 32'(lows), 32'd96);
    cmp("hsync_delay", 32'(first - t0), 32'd4);

    // Blink: phase flips after the 2nd and 4th frame start.
    blink_exp[0] = 12'hFFF;
    blink_exp[1] = 12'h00A;
    blink_exp[2] = 12'h00A;
    blink_exp[3] = 12'hFFF;
    for (int p = 0; p < 4; p++) begin
      v = vdef();
      v.von = 1'b0;
      v.vs  = ~IDLE;
      step(v, 1'b0, 12'h000);
      step(v, 1'b0, 12'h000);
      v.vs = IDLE;
      step(v, 1'b0, 12'h000);
      step(v, 1'b0, 12'h000);
      v = vdef();
      v.x = 11'd16;
      step(v, 1'b1, blink_exp[p]);
      v.von = 1'b0;
      for (int i = 0; i < 4; i++) step(v, 1'b0, 12'h000);
    end

    // Random traffic including mid-frame resets, collisions and cursor hits.
    for (int i = 0; i < 3000; i++) begin
      v       = vdef();
      v.rst_n = ($urandom_range(0, 249) != 0);
      v.x     = 11'($urandom_range(0, 639));
      v.y     = 11'($urandom_range(0, 479));
      v.von   = ($urandom_range(0, 7) != 0);
      v.hs    = ($urandom_range(0, 5) != 0) ? IDLE : ~IDLE;
      v.vs    = ($urandom_range(0, 11) == 0) ? ~IDLE : IDLE;
      v.we    = ($urandom_range(0, 15) == 0);
      v.cen   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        v.ccol = 7'(v.x / 8);
        v.crow = 6'(v.y / 8);
      end else begin
        v.ccol = 7'($urandom_range(0, 127));
        v.crow = 6'($urandom_range(0, 63));
      end
      step(v, 1'b0, 12'h000);
    end
    v = vdef();
    v.von = 1'b0;
    for (int i = 0; i < 6; i++) step(v, 1'b0, 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
